// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: clears x1..x31 after reset, then arbitrates two
// writeback requesters. Optional build macro RFARB_FIXED_PRIO_EN selects fixed priority (req0 wins).
module regfile_write_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  output logic          init_done
);

  typedef enum logic {INIT, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_addr_q, rf_addr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          init_done_q, init_done_d;
  logic          grant0, grant1;

`ifdef RFARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`else
  logic rr_ptr_q, rr_ptr_d;

  // rr_ptr only arbitrates conflicts; after a conflict the loser gets the next one.
  always_comb begin
    grant0   = req0_valid && (!req1_valid || !rr_ptr_q);
    grant1   = req1_valid && (!req0_valid ||  rr_ptr_q);
    rr_ptr_d = rr_ptr_q;
    if (state_q == RUN && req0_valid && req1_valid)
      rr_ptr_d = ~grant1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign req0_ready = (state_q == RUN) && grant0;
  assign req1_ready = (state_q == RUN) && grant1;

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    init_done_d = init_done_q;
    unique case (state_q)
      INIT: begin
        rf_we_d     = 1'b1;
        rf_addr_d   = sweep_cnt_q;
        rf_wdata_d  = '0;
        sweep_cnt_d = sweep_cnt_q + AW'(1);
        if (sweep_cnt_q == AW'(NREG - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // A write to x0 is accepted but never reaches the register file.
        if (req0_valid && req0_ready) begin
          rf_addr_d  = req0_addr;
          rf_wdata_d = req0_data;
          rf_we_d    = (req0_addr != '0);
        end else if (req1_valid && req1_ready) begin
          rf_addr_d  = req1_addr;
          rf_wdata_d = req1_data;
          rf_we_d    = (req1_addr != '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      sweep_cnt_q <= AW'(1);
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear sweep, single/conflicting requests, x0 writes
// and asynchronous reset mid-sweep and mid-write.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        init_done;

  int checks   = 0;
  int failures = 0;
  logic exp_win [4];

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .init_done  (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follows a full clear sweep starting from the first edge after reset release.
  task automatic sweep_check();
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk); #1;
      if (i < 31) begin
        chk("sweep_ready0", {31'd0, req0_ready}, 32'd0);
        chk("sweep_ready1", {31'd0, req1_ready}, 32'd0);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      chk("sweep_we",    {31'd0, rf_we}, 32'd1);
      chk("sweep_addr",  {27'd0, rf_addr}, i);
      chk("sweep_wdata", rf_wdata, 32'd0);
      chk("sweep_done",  {31'd0, init_done}, (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
`ifdef RFARB_FIXED_PRIO_EN
    exp_win[0] = 1'b0; exp_win[1] = 1'b0; exp_win[2] = 1'b0; exp_win[3] = 1'b0;
`else
    exp_win[0] = 1'b0; exp_win[1] = 1'b1; exp_win[2] = 1'b0; exp_win[3] = 1'b1;
`endif
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    #1;
    chk("rst_we",     {31'd0, rf_we}, 32'd0);
    chk("rst_addr",   {27'd0, rf_addr}, 32'd0);
    chk("rst_wdata",  rf_wdata, 32'd0);
    chk("rst_done",   {31'd0, init_done}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Sweep with both requesters waiting: neither may be accepted before RUN.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA0003;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hBBBB0004;
    sweep_check();

    // Conflicting requests for four cycles.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11111111;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22222222;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("conf_ready0", {31'd0, req0_ready}, exp_win[k] ? 32'd0 : 32'd1);
      chk("conf_ready1", {31'd0, req1_ready}, exp_win[k] ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk("conf_we",    {31'd0, rf_we}, 32'd1);
      chk("conf_addr",  {27'd0, rf_addr}, exp_win[k] ? 32'd2 : 32'd1);
      chk("conf_wdata", rf_wdata, exp_win[k] ? 32'h22222222 : 32'h11111111);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_we",   {31'd0, rf_we}, 32'd0);
    chk("idle_addr", {27'd0, rf_addr}, exp_win[3] ? 32'd2 : 32'd1);

    // Single request from req0.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    chk("single_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("single_we",    {31'd0, rf_we}, 32'd1);
    chk("single_addr",  {27'd0, rf_addr}, 32'd5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("hold_we",    {31'd0, rf_we}, 32'd0);
    chk("hold_addr",  {27'd0, rf_addr}, 32'd5);
    chk("hold_wdata", rf_wdata, 32'hDEADBEEF);

    // Write to x0 from req1: accepted, discarded.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h00001234;
    #1;
    chk("x0_ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("x0_we",    {31'd0, rf_we}, 32'd0);
    chk("x0_addr",  {27'd0, rf_addr}, 32'd0);
    chk("x0_wdata", rf_wdata, 32'h00001234);

    // Reset in RUN, then again mid-sweep at x12.
    reset = 1'b1;
    #1;
    chk("r5_done", {31'd0, init_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      chk("r5_pre_addr", {27'd0, rf_addr}, i);
    end
    reset = 1'b1;
    #1;
    chk("r5_async_we",   {31'd0, rf_we}, 32'd0);
    chk("r5_async_addr", {27'd0, rf_addr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sweep_check();

    // Accepted write dropped by reset before its output edge.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99999999;
    #1;
    chk("r6_ready0", {31'd0, req0_ready}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("r6_we",     {31'd0, rf_we}, 32'd0);
    chk("r6_ready0_rst", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    chk("r6_edge_we",   {31'd0, rf_we}, 32'd0);
    chk("r6_edge_addr", {27'd0, rf_addr}, 32'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    sweep_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
